microsequencer: RTL and testbench
=================================

# microsequencer

Parametrised microprogram sequencer, the next-generation replacement for the fixed 12-bit, 2-bit-op sequencer that drives the microcode ROM address in the microcoded Sigma CPU. It holds the micro-program counter and a configurable-depth subroutine return stack. It adds conditional jump/call, a loop counter, stall, and sticky stack-error flags. The CPU's pipeline register and map-ROM mux feed `op`/`din`; `address` drives the CodeROM directly.

## Interface
- ADDR_WIDTH, 12: micro-address width.
- STACK_DEPTH, 4: return-stack entries (≥1).
- COUNTER_WIDTH, 8: loop-counter width; must be ≤ ADDR_WIDTH.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op  in  3  sequencer operation (encodings below).
- din  in  ADDR_WIDTH  jump/call target or counter load value.
- cond  in  1  branch condition for CJUMP/CCALL.
- stall  in  1  1 = hold all state, ignore op.
- address  out  ADDR_WIDTH  current micro-address (registered µPC).
- depth  out  clog2(STACK_DEPTH+1)  entries currently on stack.
- ctr_zero  out  1  loop counter == 0.
- overflow  out  1  sticky: CALL attempted with stack full.
- underflow  out  1  sticky: RET attempted with stack empty.

## Operation
- Ops: 0 NEXT µPC+1; 1 JUMP din; 2 CALL push µPC+1, go din; 3 RET pop into µPC; 4 CJUMP cond ? din : µPC+1; 5 CCALL cond ? CALL : NEXT; 6 LDCTR ctr ← din[COUNTER_WIDTH-1:0], µPC+1; 7 LOOP ctr≠0 ? (ctr−1, go din) : µPC+1.
- µPC+1 wraps modulo 2^ADDR_WIDTH (max → 0); pushed return address wraps identically.
- CALL/CCALL-taken with depth == STACK_DEPTH: jump still taken, return address discarded, stack unchanged, overflow ← 1.
- RET with depth == 0: µPC ← µPC+1, underflow ← 1, depth stays 0.
- CCALL not taken never sets overflow, even when full.
- LOOP at ctr == 0 falls through and does not decrement (no wrap to all-ones).
- overflow/underflow clear only on reset.
- stall = 1: µPC, stack, depth, ctr, flags all hold; op/din/cond ignored.

## Timing
- Reset asserted: immediately address = 0, depth = 0, ctr = 0 (ctr_zero = 1), overflow = 0, underflow = 0; stack contents don't-care.
- Reset deasserted: first rising edge with reset = 1 executes op normally.
- op/din/cond/stall sampled on rising clock; address updates same edge; latency one cycle, no combinational path from any input to address.
- depth, ctr_zero updated on the same edge as address; stack top after CALL is readable by a RET on the very next cycle (back-to-back CALL/RET returns to µPC+1 of the CALL).
- Reset mid-operation (any op, any stall) aborts at once; no partial push/pop survives.

## Structure
- Shared package/header `microsequencer_pkg`: op encodings (NEXT…LOOP) as named constants; used by CPU microcode field decode and assembler tables.
- One sub-module `microsequencer_stack`: parametrised LIFO (WIDTH=ADDR_WIDTH, DEPTH=STACK_DEPTH) with push, pop, top, full, empty, depth; same clock/reset.
- Top holds µPC, counter, flags, next-address mux.

## Test plan
- Reset then 5× NEXT -> address 0,1,2,3,4,5; depth 0, flags 0.
- At µPC 0x010 CALL din=0x100, NEXT, RET -> address 0x100, 0x101, 0x011; depth 1 then 0.
- LDCTR din=3 at 0x020, then LOOP din=0x020 repeatedly -> jumps 3 times (ctr 2,1,0), 4th LOOP falls through to 0x021, ctr_zero = 1.
- STACK_DEPTH=4: five nested CALLs -> overflow = 1 after 5th, depth 4, 5th target still reached; five RETs -> fourth returns correctly, fifth sets underflow, address = µPC+1.
- µPC = 0xFFF, NEXT -> 0x000; CJUMP cond=0 din=0x200 -> 0x001; cond=1 -> 0x200; stall=1 for 3 cycles with JUMP -> address unchanged.
- Assert reset during CALL with stall=0 mid-sequence -> address 0, depth 0, ctr_zero 1, flags 0 before next edge.

Source files
------------

// File: rtl/microsequencer_pkg.sv
// microsequencer_pkg: op encodings shared by the sequencer RTL, the CPU
// microcode field decode and the microassembler tables.
package microsequencer_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT  = 3'd0,  // upc + 1
    OP_JUMP  = 3'd1,  // din
    OP_CALL  = 3'd2,  // push upc + 1, go din
    OP_RET   = 3'd3,  // pop into upc
    OP_CJUMP = 3'd4,  // cond ? din : upc + 1
    OP_CCALL = 3'd5,  // cond ? CALL : NEXT
    OP_LDCTR = 3'd6,  // ctr <- din, upc + 1
    OP_LOOP  = 3'd7   // ctr != 0 ? (ctr - 1, go din) : upc + 1
  } op_e;

endpackage

// File: rtl/microsequencer_stack.sv
// microsequencer_stack: parametrised LIFO holding subroutine return addresses.
//   clock, reset : rising-edge clock, async active-low reset (empties stack)
//   push, pop    : ignored when full / empty respectively; never both at once
//   din          : value pushed
//   top          : most recent entry ('0 when empty)
//   full, empty  : occupancy flags
//   depth        : entries currently held
module microsequencer_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);
  import microsequencer_pkg::*;

  localparam int DW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       depth <= '0;
    else if (do_push) depth <= depth + DW'(1);
    else if (do_pop)  depth <= depth - DW'(1);
  end

  // Storage needs no reset: entries above depth are never read.
  // Slot selection by compare avoids indexing with an over-wide depth value.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++)
      if (do_push && depth == DW'(i)) mem[i] <= din;
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (depth == DW'(i + 1)) top = mem[i];
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer: microprogram sequencer driving the CodeROM address.
//   clock, reset : rising-edge clock, async active-low reset
//   op, din, cond: operation, jump/call target or counter value, branch condition
//   stall        : hold all state, op ignored
//   address      : registered micro-PC
//   depth        : return-stack occupancy
//   ctr_zero     : loop counter is zero
//   overflow     : sticky, CALL attempted with full stack
//   underflow    : sticky, RET attempted with empty stack
module microsequencer #(
  parameter int ADDR_WIDTH    = 12,
  parameter int STACK_DEPTH   = 4,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [2:0]                           op,
  input  logic [ADDR_WIDTH-1:0]                din,
  input  logic                                 cond,
  input  logic                                 stall,
  output logic [ADDR_WIDTH-1:0]                address,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
  output logic                                 ctr_zero,
  output logic                                 overflow,
  output logic                                 underflow
);
  import microsequencer_pkg::*;

  logic [ADDR_WIDTH-1:0]    upc, upc_inc, upc_nxt, stk_top;
  logic [COUNTER_WIDTH-1:0] ctr, ctr_nxt;
  logic                     push, pop, stk_full, stk_empty;
  logic                     ovf_set, unf_set;
  op_e                      op_sel;

  assign op_sel   = op_e'(op);
  assign upc_inc  = upc + ADDR_WIDTH'(1);  // wraps max -> 0, also for return addr
  assign address  = upc;
  assign ctr_zero = (ctr == '0);

  microsequencer_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (upc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (depth)
  );

  // Next-address mux. Stall forces hold: no push/pop, no flag or counter change.
  always_comb begin
    upc_nxt = upc;
    ctr_nxt = ctr;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!stall) begin
      upc_nxt = upc_inc;
      unique case (op_sel)
        OP_NEXT: ;
        OP_JUMP: upc_nxt = din;
        OP_CALL: begin
          upc_nxt = din;
          if (stk_full) ovf_set = 1'b1;  // target still taken, return addr dropped
          else          push    = 1'b1;
        end
        OP_RET: begin
          if (stk_empty) unf_set = 1'b1;  // fall through to upc + 1
          else begin
            upc_nxt = stk_top;
            pop     = 1'b1;
          end
        end
        OP_CJUMP: if (cond) upc_nxt = din;
        OP_CCALL: begin
          if (cond) begin
            upc_nxt = din;
            if (stk_full) ovf_set = 1'b1;
            else          push    = 1'b1;
          end
        end
        OP_LDCTR: ctr_nxt = din[COUNTER_WIDTH-1:0];
        OP_LOOP: begin
          // At zero fall through without decrementing.
          if (ctr != '0) begin
            upc_nxt = din;
            ctr_nxt = ctr - COUNTER_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upc       <= '0;
      ctr       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      upc       <= upc_nxt;
      ctr       <= ctr_nxt;
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;
  import microsequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [11:0] din   = '0;
  logic        cond  = 1'b0;
  logic        stall = 1'b0;
  logic [11:0] address;
  logic [2:0]  depth;
  logic        ctr_zero, overflow, underflow;

  int tests = 0;
  int fails = 0;

  microsequencer #(.ADDR_WIDTH(12), .STACK_DEPTH(4), .COUNTER_WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .op        (op),
    .din       (din),
    .cond      (cond),
    .stall     (stall),
    .address   (address),
    .depth     (depth),
    .ctr_zero  (ctr_zero),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        stall;
    logic [2:0]  op;
    logic [11:0] din;
    logic        cond;
    logic [11:0] addr;
    logic [2:0]  depth;
    logic        cz;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, logic st, logic [2:0] o, logic [11:0] d,
                              logic c, logic [11:0] a, logic [2:0] dp,
                              logic cz, logic ov, logic un);
    vec_t v;
    v.name = nm; v.stall = st; v.op = o; v.din = d; v.cond = c;
    v.addr = a; v.depth = dp; v.cz = cz; v.ovf = ov; v.unf = un;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [11:0] a, logic [2:0] dp,
                         logic cz, logic ov, logic un);
    chk({nm, ".addr"},  32'(address),   32'(a));
    chk({nm, ".depth"}, 32'(depth),     32'(dp));
    chk({nm, ".cz"},    32'(ctr_zero),  32'(cz));
    chk({nm, ".ovf"},   32'(overflow),  32'(ov));
    chk({nm, ".unf"},   32'(underflow), 32'(un));
  endtask

  initial begin
    //   name        st op        din     c  addr    dp cz ov un
    add("next1",    0, OP_NEXT,  12'h000, 0, 12'h001, 0, 1, 0, 0);
    add("next2",    0, OP_NEXT,  12'h000, 0, 12'h002, 0, 1, 0, 0);
    add("next3",    0, OP_NEXT,  12'h000, 0, 12'h003, 0, 1, 0, 0);
    add("next4",    0, OP_NEXT,  12'h000, 0, 12'h004, 0, 1, 0, 0);
    add("next5",    0, OP_NEXT,  12'h000, 0, 12'h005, 0, 1, 0, 0);
    add("jmp010",   0, OP_JUMP,  12'h010, 0, 12'h010, 0, 1, 0, 0);
    add("call100",  0, OP_CALL,  12'h100, 0, 12'h100, 1, 1, 0, 0);
    add("sub_next", 0, OP_NEXT,  12'h000, 0, 12'h101, 1, 1, 0, 0);
    add("ret011",   0, OP_RET,   12'h000, 0, 12'h011, 0, 1, 0, 0);
    add("jmp020",   0, OP_JUMP,  12'h020, 0, 12'h020, 0, 1, 0, 0);
    add("ldctr3",   0, OP_LDCTR, 12'h003, 0, 12'h021, 0, 0, 0, 0);
    add("loop_c2",  0, OP_LOOP,  12'h020, 0, 12'h020, 0, 0, 0, 0);
    add("loop_c1",  0, OP_LOOP,  12'h020, 0, 12'h020, 0, 0, 0, 0);
    add("loop_c0",  0, OP_LOOP,  12'h020, 0, 12'h020, 0, 1, 0, 0);
    add("loop_out", 0, OP_LOOP,  12'h020, 0, 12'h021, 0, 1, 0, 0);
    add("loop_hold",0, OP_LOOP,  12'h020, 0, 12'h022, 0, 1, 0, 0);
    add("jmp040",   0, OP_JUMP,  12'h040, 0, 12'h040, 0, 1, 0, 0);
    add("ncall1",   0, OP_CALL,  12'h100, 0, 12'h100, 1, 1, 0, 0);
    add("ncall2",   0, OP_CALL,  12'h200, 0, 12'h200, 2, 1, 0, 0);
    add("ncall3",   0, OP_CALL,  12'h300, 0, 12'h300, 3, 1, 0, 0);
    add("ncall4",   0, OP_CALL,  12'h400, 0, 12'h400, 4, 1, 0, 0);
    add("ccall_nt", 0, OP_CCALL, 12'h777, 0, 12'h401, 4, 1, 0, 0);
    add("ncall5",   0, OP_CALL,  12'h500, 0, 12'h500, 4, 1, 1, 0);
    add("nret4",    0, OP_RET,   12'h000, 0, 12'h301, 3, 1, 1, 0);
    add("nret3",    0, OP_RET,   12'h000, 0, 12'h201, 2, 1, 1, 0);
    add("nret2",    0, OP_RET,   12'h000, 0, 12'h101, 1, 1, 1, 0);
    add("nret1",    0, OP_RET,   12'h000, 0, 12'h041, 0, 1, 1, 0);
    add("nret_unf", 0, OP_RET,   12'h000, 0, 12'h042, 0, 1, 1, 1);
    add("ccall_t",  0, OP_CCALL, 12'h600, 1, 12'h600, 1, 1, 1, 1);
    add("b2b_ret",  0, OP_RET,   12'h000, 0, 12'h043, 0, 1, 1, 1);
    add("jmpfff_a", 0, OP_JUMP,  12'hFFF, 0, 12'hFFF, 0, 1, 1, 1);
    add("call_wrap",0, OP_CALL,  12'h123, 0, 12'h123, 1, 1, 1, 1);
    add("ret_wrap", 0, OP_RET,   12'h000, 0, 12'h000, 0, 1, 1, 1);
    add("jmpfff_b", 0, OP_JUMP,  12'hFFF, 0, 12'hFFF, 0, 1, 1, 1);
    add("next_wrap",0, OP_NEXT,  12'h000, 0, 12'h000, 0, 1, 1, 1);
    add("cjmp_nt",  0, OP_CJUMP, 12'h200, 0, 12'h001, 0, 1, 1, 1);
    add("cjmp_t",   0, OP_CJUMP, 12'h200, 1, 12'h200, 0, 1, 1, 1);
    add("stall_j1", 1, OP_JUMP,  12'h7AB, 0, 12'h200, 0, 1, 1, 1);
    add("stall_j2", 1, OP_JUMP,  12'h7AB, 0, 12'h200, 0, 1, 1, 1);
    add("stall_j3", 1, OP_JUMP,  12'h7AB, 0, 12'h200, 0, 1, 1, 1);
    add("stall_ld", 1, OP_LDCTR, 12'h005, 0, 12'h200, 0, 1, 1, 1);
    add("stall_cl", 1, OP_CALL,  12'h333, 0, 12'h200, 0, 1, 1, 1);
    add("ldctr5",   0, OP_LDCTR, 12'h005, 0, 12'h201, 0, 0, 1, 1);
    add("call_pre", 0, OP_CALL,  12'h300, 0, 12'h300, 1, 0, 1, 1);

    // Reset held at time zero: outputs must already be at reset values.
    #1;
    chk_all("reset", 12'h000, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      stall = vecs[i].stall;
      op    = vecs[i].op;
      din   = vecs[i].din;
      cond  = vecs[i].cond;
      @(posedge clock);
      #1;
      chk_all(vecs[i].name, vecs[i].addr, vecs[i].depth, vecs[i].cz,
              vecs[i].ovf, vecs[i].unf);
    end

    // Reset mid-sequence while a CALL is presented: clears before any edge.
    stall = 1'b0; op = OP_CALL; din = 12'h3C0; cond = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk_all("mid_rst", 12'h000, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    // First edge after release executes the pending CALL.
    @(posedge clock);
    #1;
    chk_all("post_rst_call", 12'h3C0, 3'd1, 1'b1, 1'b0, 1'b0);
    op = OP_RET;
    @(posedge clock);
    #1;
    chk_all("post_rst_ret", 12'h001, 3'd0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
